// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int unsigned SERIAL_SUB_W_MAX = 32;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Operand/result handshake bundle between a producer/consumer and serial_sub_ctrl.
interface serial_sub_ctrl_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff_out;
    logic         borrow_out;
    logic         busy;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, diff_out, borrow_out, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, diff_out, borrow_out, busy
    );
endinterface

// File: rtl/sub_bit_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
module sub_bit_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    always_comb begin
        d_o    = a_i ^ b_i ^ bin_i;
        bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
    end
endmodule

// File: rtl/serial_sub_ctrl.sv
// Sequencer time-sharing one sub_bit_cell across W bits, LSB first.
// Optional SERIAL_SUB_SAT_EN: diff_out forced to 0 when the final borrow is set.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_sub_ctrl_if.slave   bus
);
    localparam int unsigned CntW = $clog2(W + 1);

    if (W < 1 || W > SERIAL_SUB_W_MAX) begin : g_bad_width
        $error("serial_sub_ctrl: W out of range");
    end

    state_e          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    res_q;
    logic            bor_q;
    logic [CntW-1:0] cnt_q;

    logic            d;
    logic            bout;
    logic [W-1:0]    res_d;
    logic [W-1:0]    diff_d;

    sub_bit_cell u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (bor_q),
        .d_o    (d),
        .bout_o (bout)
    );

    // Each new bit enters at the MSB so after W shifts bit 0 holds the LSB.
    always_comb begin
        res_d  = (res_q >> 1) | (W'(d) << (W - 1));
        diff_d = res_d;
`ifdef SERIAL_SUB_SAT_EN
        if (bout) begin
            diff_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            res_q          <= '0;
            bor_q          <= 1'b0;
            cnt_q          <= '0;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.diff_out   <= '0;
            bus.borrow_out <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q          <= bus.a_in;
                        b_q          <= bus.b_in;
                        bor_q        <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= RUN;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    bor_q <= bout;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(W - 1)) begin
                        state_q        <= DONE;
                        bus.out_valid  <= 1'b1;
                        bus.diff_out   <= diff_d;
                        bus.borrow_out <= bout;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q       <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (W=8 and W=1 instances); honours SERIAL_SUB_SAT_EN.
module tb_serial_sub_ctrl;
    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    serial_sub_ctrl_if #(.W(8)) bus8 ();
    serial_sub_ctrl_if #(.W(1)) bus1 ();

    serial_sub_ctrl #(.W(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_sub_ctrl #(.W(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        int         hold;
    } vec_t;

    vec_t tbl[6];

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Reference: unsigned subtract modulo 2^w, borrow when a < b.
    function automatic void model(input int unsigned w, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] d,
                                  output logic bo);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        bo   = (a & mask) < (b & mask);
        d    = (a - b) & mask;
`ifdef SERIAL_SUB_SAT_EN
        if (bo) d = '0;
`endif
    endfunction

    task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic ordy);
        @(negedge clk);
        bus8.a_in      = a;
        bus8.b_in      = b;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = ordy;
        chk("in_ready_before_accept", 32'(bus8.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        bus8.a_in     = 8'($urandom);
        bus8.b_in     = 8'($urandom);
        chk("busy_after_accept", 32'(bus8.busy), 32'd1);
    endtask

    task automatic wait_ov8(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus8.out_valid && cyc < 40);
    endtask

    task automatic finish8(input logic [7:0] ed, input logic eb, input int hold);
        chk("diff_out", 32'(bus8.diff_out), 32'(ed));
        chk("borrow_out", 32'(bus8.borrow_out), 32'(eb));
        chk("in_ready_in_done", 32'(bus8.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", 32'(bus8.out_valid), 32'd1);
            chk("hold_diff", 32'(bus8.diff_out), 32'(ed));
            chk("hold_borrow", 32'(bus8.borrow_out), 32'(eb));
            chk("hold_in_ready", 32'(bus8.in_ready), 32'd0);
        end
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("out_valid_release", 32'(bus8.out_valid), 32'd0);
        chk("in_ready_after_release", 32'(bus8.in_ready), 32'd1);
        chk("busy_after_release", 32'(bus8.busy), 32'd0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                        input logic eb, input int hold);
        int cyc;
        accept8(a, b, (hold == 0) ? 1'b1 : 1'b0);
        wait_ov8(cyc);
        chk("latency8", 32'(cyc), 32'd8);
        finish8(ed, eb, hold);
    endtask

    task automatic run1(input logic a, input logic b);
        logic [31:0] ed;
        logic        eb;
        model(1, 32'(a), 32'(b), ed, eb);
        @(negedge clk);
        bus1.a_in     = a;
        bus1.b_in     = b;
        bus1.in_valid = 1'b1;
        chk("w1_in_ready", 32'(bus1.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        chk("w1_out_valid_pre", 32'(bus1.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("w1_out_valid", 32'(bus1.out_valid), 32'd1);
        chk("w1_diff", 32'(bus1.diff_out), ed);
        chk("w1_borrow", 32'(bus1.borrow_out), 32'(eb));
        @(posedge clk);
        #1;
        chk("w1_release", 32'(bus1.out_valid), 32'd0);
        chk("w1_in_ready_back", 32'(bus1.in_ready), 32'd1);
    endtask

    initial begin
        int          cyc;
        int          ov;
        logic [31:0] md;
        logic        mb;
        logic [7:0]  ra;
        logic [7:0]  rb;

        vectors     = 0;
        miscompares = 0;

        tbl[0] = '{a: 8'd200, b: 8'd55,  d: 8'd145, bo: 1'b0, hold: 0};
`ifdef SERIAL_SUB_SAT_EN
        tbl[1] = '{a: 8'd10,  b: 8'd20,  d: 8'h00,  bo: 1'b1, hold: 0};
        tbl[3] = '{a: 8'd0,   b: 8'd255, d: 8'h00,  bo: 1'b1, hold: 0};
        tbl[5] = '{a: 8'd128, b: 8'd129, d: 8'h00,  bo: 1'b1, hold: 5};
`else
        tbl[1] = '{a: 8'd10,  b: 8'd20,  d: 8'hF6,  bo: 1'b1, hold: 0};
        tbl[3] = '{a: 8'd0,   b: 8'd255, d: 8'h01,  bo: 1'b1, hold: 0};
        tbl[5] = '{a: 8'd128, b: 8'd129, d: 8'hFF,  bo: 1'b1, hold: 5};
`endif
        tbl[2] = '{a: 8'd100, b: 8'd3,   d: 8'd97,  bo: 1'b0, hold: 0};
        tbl[4] = '{a: 8'd255, b: 8'd0,   d: 8'd255, bo: 1'b0, hold: 1};

        rst_n          = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.a_in      = '0;
        bus8.b_in      = '0;
        bus8.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.a_in      = '0;
        bus1.b_in      = '0;
        bus1.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_diff", 32'(bus8.diff_out), 32'd0);
        chk("rst_borrow", 32'(bus8.borrow_out), 32'd0);
        chk("rst_w1_in_ready", 32'(bus1.in_ready), 32'd1);

        // No capture while in_valid stays low.
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_capture", 32'(bus8.busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run8(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo, tbl[i].hold);
        end

        // in_valid during RUN must be ignored.
        accept8(8'd100, 8'd3, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus8.a_in     = 8'd1;
        bus8.b_in     = 8'd1;
        bus8.in_valid = 1'b1;
        chk("in_ready_in_run", 32'(bus8.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        wait_ov8(cyc);
        chk("latency_after_ignore", 32'(cyc), 32'd5);
        finish8(8'd97, 1'b0, 0);
        ov = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus8.out_valid) ov++;
        end
        chk("no_second_out_valid", 32'(ov), 32'd0);

        // Reset at RUN cycle 4 discards the operation.
        accept8(8'd50, 8'd20, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", 32'(bus8.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("midrst_busy", 32'(bus8.busy), 32'd0);
        chk("midrst_diff", 32'(bus8.diff_out), 32'd0);
        chk("midrst_borrow", 32'(bus8.borrow_out), 32'd0);
        ov = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus8.out_valid) ov++;
        end
        chk("midrst_no_out_valid", 32'(ov), 32'd0);
        run8(8'd7, 8'd7, 8'd0, 1'b0, 0);

        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 5 == 0) rb = ra;
            model(8, 32'(ra), 32'(rb), md, mb);
            run8(ra, rb, md[7:0], mb, int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < 4; i++) begin
            run1(i[1], i[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
